regfile_writeback: RTL
======================

# regfile_writeback

Write-side front end for the 32x32 register file: merges ALU results and load-return data into the register file's single write port (w_en / w_address_d_5 / w_data_dval_32). ALU results have strict priority; load returns are buffered in a small FIFO with a valid/ready handshake. The block also exports a pending-write mask for hazard detection in decode.

## Interface
- DEPTH, 4, load FIFO entries (power of two, ≥2)
- clock  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid this cycle (cannot be stalled)
- alu_dest_5  in  5  ALU destination register
- alu_data_32  in  32  ALU result
- mem_valid  in  1  load return valid
- mem_dest_5  in  5  load destination register
- mem_data_32  in  32  load data
- mem_ready  out  1  FIFO can accept a load (registered)
- w_en  out  1  register file write enable (registered)
- w_address_d_5  out  5  register file write address (registered)
- w_data_dval_32  out  32  register file write data (registered)
- pending_mask_32  out  32  bit r set while a write to r is queued or in the output stage
- wb_idle  out  1  FIFO empty and w_en low

## Operation
- Output stage selects per cycle, in priority order: ALU result if alu_valid and alu_dest_5≠0; else FIFO head if FIFO non-empty (pop); else nothing (w_en←0).
- Load accepted when mem_valid && mem_ready; pushed to FIFO unless mem_dest_5=0 (handshake completes, data discarded).
- ALU writes to register 0 are dropped; w_en never asserts with w_address_d_5=0.
- FIFO: read/write pointers of log2(DEPTH) bits wrap modulo DEPTH; count 0..DEPTH. Push and pop in the same cycle leave count unchanged, valid at any count ≥1.
- mem_ready next = (count_next < DEPTH). When full, mem_ready is low even if a pop occurs that cycle; it rises the following cycle.
- pending_mask_32 = OR of decoded destinations of all valid FIFO entries plus the output stage when w_en=1; combinational from state. Duplicate destinations keep the bit set until the last one drains. Bit 0 always 0.
- Load ordering preserved (FIFO); ALU vs load order for the same register is not preserved, decode must use pending_mask_32.
- When w_en=1, w_address_d_5/w_data_dval_32 hold the selected entry; when w_en=0 they hold their previous values.

## Timing
- Reset (async assert): w_en=0, w_address_d_5=0, w_data_dval_32=0, FIFO empty, mem_ready=0, pending_mask_32=0, wb_idle=1. mem_ready rises on the first posedge after reset_n deasserts.
- Reset mid-operation: all queued loads lost, outputs return to reset values immediately.
- ALU latency: alu_valid in cycle N → w_en in cycle N+1.
- Load latency (no ALU contention): accept in N → enters FIFO at N+1 edge → w_en in N+2.
- Each ALU cycle delays the FIFO head by one cycle; continuous ALU traffic starves the FIFO indefinitely (by design, pipeline guarantees gaps).
- Register file samples w_en on the posedge ending the cycle in which it is high.

## Configuration
- WB_BYPASS_EN defined: when FIFO is empty, no valid ALU write is selected, and a load with dest≠0 is accepted in cycle N, it goes straight to the output stage (w_en in N+1) without being pushed.
- Undefined: every load passes through the FIFO (minimum latency 2 cycles).

## Structure
- Package regfile_wb_pkg: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, typedef wb_entry_t {dest[4:0], data[31:0]}.
- One sub-module: wb_fifo (parameter DEPTH; push/pop, head entry, count, per-entry valid vector for mask generation). Arbitration, output register, and mask in top level.

## Test plan
- Reset: assert reset_n=0 mid-traffic with 3 loads queued → all outputs at reset values, FIFO empty; mem_ready=1 one cycle after release.
- ALU only: alu_valid, dest=5, data=0x12345678 in cycle N → w_en=1, addr=5, data=0x12345678 in N+1; dest=0 → no w_en.
- Contention: load dest=7 data=0xA accepted in N, ALU dest=3 in N+1 → N+2 writes r3, N+3 writes r7; pending_mask_32 bit 7 set N+1..N+3.
- Full FIFO (DEPTH=4): 4 loads with continuous ALU → mem_ready low; a 5th mem_valid is not accepted; after ALU stops, loads drain in order, mem_ready rises the cycle after the first pop.
- Wrap-around: 10 loads dests 1..10 interleaved with random ALU gaps → all writes appear in load order, no loss, no duplicates.
- WB_BYPASS_EN: idle block, load dest=9 accepted in N → w_en in N+1 (N+2 without the macro).

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_pkg
// Purpose  : Shared widths, the write-back entry type and a destination
//            decoder for the register-file write-side front end.
// Contents : REG_ADDR_W, REG_DATA_W, NUM_REGS, wb_entry_t, dest_onehot()
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot decode of a destination register. Register 0 is hard-wired
    // and never reported as pending.
    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] dest);
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[dest] = 1'b1;
        oh[0]    = 1'b0;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_if
// Purpose  : Bundle of the ALU result port, the load-return handshake and the
//            register-file write port plus hazard outputs.
// Modports : master - producer side (drives ALU/load, observes write port)
//            slave  - write-back block
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_writeback_if;
    import regfile_wb_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_dest_5;
    logic [REG_DATA_W-1:0] alu_data_32;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_dest_5;
    logic [REG_DATA_W-1:0] mem_data_32;
    logic                  mem_ready;
    logic                  w_en;
    logic [REG_ADDR_W-1:0] w_address_d_5;
    logic [REG_DATA_W-1:0] w_data_dval_32;
    logic [NUM_REGS-1:0]   pending_mask_32;
    logic                  wb_idle;

    modport master (
        output alu_valid, alu_dest_5, alu_data_32,
        output mem_valid, mem_dest_5, mem_data_32,
        input  mem_ready, w_en, w_address_d_5, w_data_dval_32,
        input  pending_mask_32, wb_idle
    );

    modport slave (
        input  alu_valid, alu_dest_5, alu_data_32,
        input  mem_valid, mem_dest_5, mem_data_32,
        output mem_ready, w_en, w_address_d_5, w_data_dval_32,
        output pending_mask_32, wb_idle
    );

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Load-return buffer. Power-of-two depth, wrapping pointers,
//            occupancy count 0..DEPTH, per-slot valid and destination
//            vectors for pending-write mask generation.
// Ports    : clock, reset_n (async active-low), push/push_entry, pop,
//            head, count, entry_valid, entry_dest
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                                  clock,
    input  wire logic                                  reset_n,
    input  wire logic                                  push,
    input  wire wb_entry_t                             push_entry,
    input  wire logic                                  pop,
    output wb_entry_t                                  head,
    output logic [$clog2(DEPTH+1)-1:0]                 count,
    output logic [DEPTH-1:0]                           entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]           entry_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    logic [PTR_W-1:0] offset;

    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy count.
    always_comb begin
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = (CNT_W'(offset) < count_q);
            entry_dest[i]  = mem_q[i].dest;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Merges ALU results (strict priority, never stalled) and
//            load returns (FIFO-buffered, valid/ready) onto the register
//            file's single registered write port; exports a pending-write
//            mask for decode hazard detection.
// Ports    : clock, reset_n (async active-low), wb (regfile_writeback_if.slave)
// Options  : WB_BYPASS_EN - a load accepted while the FIFO is empty and no
//            ALU write is selected goes straight to the output stage.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    regfile_writeback_if.slave  wb
);

    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t                        fifo_head;
    wb_entry_t                        push_entry;
    logic [CNT_W-1:0]                 fifo_count;
    logic [CNT_W-1:0]                 count_next;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_dest;

    logic alu_sel, fifo_empty, load_accept, load_keep, bypass, push, pop;

    logic                  w_en_q, w_en_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [REG_DATA_W-1:0] w_data_q, w_data_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [NUM_REGS-1:0]   pending_mask;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
    );

    always_comb begin
        alu_sel     = wb.alu_valid && (wb.alu_dest_5 != '0);
        fifo_empty  = (fifo_count == '0);
        load_accept = wb.mem_valid && mem_ready_q;
        // Loads to r0 complete the handshake but are discarded.
        load_keep   = load_accept && (wb.mem_dest_5 != '0);
        pop         = !alu_sel && !fifo_empty;
`ifdef WB_BYPASS_EN
        bypass      = load_keep && fifo_empty && !alu_sel;
`else
        bypass      = 1'b0;
`endif
        push        = load_keep && !bypass;
        push_entry  = '{dest: wb.mem_dest_5, data: wb.mem_data_32};

        w_en_d   = alu_sel || pop || bypass;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (alu_sel) begin
            w_addr_d = wb.alu_dest_5;
            w_data_d = wb.alu_data_32;
        end else if (pop) begin
            w_addr_d = fifo_head.dest;
            w_data_d = fifo_head.data;
        end else if (bypass) begin
            w_addr_d = wb.mem_dest_5;
            w_data_d = wb.mem_data_32;
        end

        // Ready is registered from next occupancy, so a full FIFO keeps
        // ready low through the popping cycle and raises it one cycle later.
        count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
        mem_ready_d = (count_next < CNT_W'(DEPTH));
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask = pending_mask | dest_onehot(entry_dest[i]);
            end
        end
        if (w_en_q) begin
            pending_mask = pending_mask | dest_onehot(w_addr_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign wb.mem_ready       = mem_ready_q;
    assign wb.w_en            = w_en_q;
    assign wb.w_address_d_5   = w_addr_q;
    assign wb.w_data_dval_32  = w_data_q;
    assign wb.pending_mask_32 = pending_mask;
    assign wb.wb_idle         = fifo_empty && !w_en_q;

endmodule
`default_nettype wire
